arrow_vote_filter: RTL and testbench
====================================

Name: arrow_vote_filter

Overview:
- Downstream consumer of the 8-neuron arrow classifier array; samples its registered 8-bit neuron vector once per frame.
- Reduces each frame to a single verdict: arrow direction, no arrow, or ambiguous.
- Suppresses flicker by requiring STABLE_FRAMES identical consecutive verdicts before committing a result.
- Emits each committed change once, over a valid/ready handshake, to the display/control logic.

Parameters:
- STABLE_FRAMES, 3, number of consecutive identical frame verdicts required to commit; legal range 1..15.
- CNT_W, 4, width of the run counter; must satisfy 2**CNT_W > STABLE_FRAMES.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- neuron_in  input  8  neuron firing vector; bit order 0 up, 1 up-left, 2 left-down, 3 left, 4 down, 5 up-right, 6 down-right, 7 right
- in_valid  input  1  neuron_in holds a new frame result this cycle
- out_valid  output  1  committed verdict available
- out_ready  input  1  consumer accepts the verdict when high together with out_valid
- out_kind  output  2  00 arrow, 01 none (no bit set), 10 ambiguous (2+ bits set), 11 unused
- out_dir  output  3  index of the firing neuron when out_kind=00; 0 otherwise

Behaviour:
- Reset (async assert, sync-release domain of clk): out_valid=0, out_kind=0, out_dir=0, run counter=0, last verdict cleared, has_commit=0.
- Frame verdict (combinational, only used when in_valid=1):
  - popcount(neuron_in)=1 -> kind 00, dir = set bit index.
  - popcount=0 -> kind 01, dir 0.
  - popcount>=2 -> kind 10, dir 0.
- Run tracking, on each in_valid cycle:
  - Verdict == last verdict: run = min(run+1, STABLE_FRAMES).
  - Otherwise: last = verdict, run = 1.
- Cycles with in_valid=0 change nothing. Gaps between frames neither break nor extend a run.
- Commit condition, evaluated in the in_valid cycle using the updated run value: run == STABLE_FRAMES, AND (has_commit=0 OR verdict != committed verdict), AND the output slot is free (out_valid=0, or out_valid=1 with out_ready=1 in this cycle).
- On commit:
  - Committed verdict register is loaded and has_commit=1.
  - out_kind/out_dir are loaded; out_valid=1 from the next cycle.
  - Latency: one clock from the completing in_valid edge.
- Output slot FSM:
  - EMPTY -> FULL on commit.
  - FULL -> EMPTY on out_ready without a same-cycle commit.
  - FULL -> FULL when out_ready and a commit coincide; the new data replaces the old and out_valid stays 1.
- While out_valid=1 and out_ready=0, out_kind/out_dir are held stable and no commit occurs. The run counter keeps updating and stays saturated, so a blocked commit is retried on the next in_valid frame after the slot frees. No verdict is silently dropped while the input stays stable.
- STABLE_FRAMES=1: every frame whose verdict differs from the committed verdict commits immediately, subject to slot availability.
- A repeat of the committed verdict never re-emits, even after an intervening shorter run of another verdict.
- Reset mid-run or mid-handshake: all state is cleared immediately, and the pending output is discarded.

Decomposition:
- Package arrow_pkg holds:
  - NUM_DIRS=8.
  - Direction index constants DIR_UP..DIR_RIGHT in the bit order above.
  - Kind codes KIND_ARROW=2'b00, KIND_NONE=2'b01, KIND_AMBIG=2'b10.
  - A verdict struct {kind, dir}.
- One sub-module, onehot_verdict: purely combinational popcount plus one-hot-to-index encoder, producing {kind, dir} from the 8-bit vector.

Test Plan:
- Reset: hold rst_n=0, drive random inputs -> out_valid=0, out_kind=0, out_dir=0 throughout; release and idle -> still 0.
- out_ready=1, three in_valid frames of 8'h01 -> out_valid=1 for exactly one cycle, one clock after the 3rd frame, with kind=00, dir=0. Fourth and fifth 8'h01 frames -> no further output.
- Frames 8'h80, 8'h80, 8'h00, 8'h80, 8'h80, 8'h80 -> no output through frame 5; single output kind=00, dir=7 after frame 6.
- Three frames of 8'h03 -> kind=10, dir=0. Then three frames of 8'h00 -> kind=01, dir=0. Two outputs total.
- out_ready=0, three frames of 8'h08 -> out_valid=1, dir=3. Then five frames of 8'h10 -> dir remains 3 and stable. Raise out_ready for one cycle -> slot empties. Next 8'h10 frame -> output kind=00, dir=4.
- Two frames of 8'h04, then pulse rst_n low between clock edges -> all outputs 0 immediately. After release, frames 1 and 2 of 8'h04 give no output; frame 3 gives dir=2.

Source files
------------

// File: rtl/arrow_pkg.sv
// rtl/arrow_pkg.sv - shared constants and verdict type for the arrow vote filter
package arrow_pkg;

    localparam int NUM_DIRS = 8;

    // Direction indices follow the classifier's neuron bit order
    localparam logic [2:0] DIR_UP         = 3'd0;
    localparam logic [2:0] DIR_UP_LEFT    = 3'd1;
    localparam logic [2:0] DIR_LEFT_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT       = 3'd3;
    localparam logic [2:0] DIR_DOWN       = 3'd4;
    localparam logic [2:0] DIR_UP_RIGHT   = 3'd5;
    localparam logic [2:0] DIR_DOWN_RIGHT = 3'd6;
    localparam logic [2:0] DIR_RIGHT      = 3'd7;

    localparam logic [1:0] KIND_ARROW = 2'b00;
    localparam logic [1:0] KIND_NONE  = 2'b01;
    localparam logic [1:0] KIND_AMBIG = 2'b10;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] dir;
    } verdict_t;

endpackage

// File: rtl/onehot_verdict.sv
// rtl/onehot_verdict.sv - combinational popcount and one-hot index encoder
import arrow_pkg::*;

module onehot_verdict (
    input  logic [NUM_DIRS-1:0] vec,
    output logic [1:0]          kind,
    output logic [2:0]          dir
);

    logic [3:0] cnt;
    logic [2:0] idx;

    always_comb begin
        cnt = 4'd0;
        idx = DIR_UP;
        for (int i = 0; i < NUM_DIRS; i++) begin
            if (vec[i]) begin
                cnt = cnt + 4'd1;
                idx = 3'(i);
            end
        end
    end

    always_comb begin
        kind = KIND_AMBIG;
        dir  = DIR_UP;
        if (cnt == 4'd0) begin
            kind = KIND_NONE;
        end else if (cnt == 4'd1) begin
            kind = KIND_ARROW;
            dir  = idx;
        end
    end

endmodule

// File: rtl/arrow_vote_filter.sv
// rtl/arrow_vote_filter.sv - debounces per-frame arrow verdicts and emits committed changes
import arrow_pkg::*;

module arrow_vote_filter #(
    parameter int STABLE_FRAMES = 3,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] neuron_in,
    input  logic       in_valid,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_kind,
    output logic [2:0] out_dir
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STABLE_FRAMES);

    slot_state_t      state, state_next;
    verdict_t         cur, last, last_next, committed;
    logic [CNT_W-1:0] run, run_next;
    logic             has_commit;
    logic             slot_free, commit;
    logic [1:0]       cur_kind;
    logic [2:0]       cur_dir;

    onehot_verdict u_verdict (
        .vec  (neuron_in),
        .kind (cur_kind),
        .dir  (cur_dir)
    );

    always_comb begin
        cur.kind = cur_kind;
        cur.dir  = cur_dir;
    end

    // Run length saturates so a blocked commit stays armed until the slot frees
    always_comb begin
        run_next  = run;
        last_next = last;
        if (in_valid) begin
            if (cur == last) begin
                run_next = (run == RUN_MAX) ? run : run + CNT_W'(1);
            end else begin
                last_next = cur;
                run_next  = CNT_W'(1);
            end
        end
    end

    assign slot_free = (state == SLOT_EMPTY) || out_ready;
    assign commit    = in_valid && (run_next == RUN_MAX) &&
                       (!has_commit || (cur != committed)) && slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= '0;
            last       <= '0;
            committed  <= '0;
            has_commit <= 1'b0;
        end else begin
            run  <= run_next;
            last <= last_next;
            if (commit) begin
                committed  <= cur;
                has_commit <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = (state == SLOT_FULL);
        case (state)
            SLOT_EMPTY: if (commit) state_next = SLOT_FULL;
            SLOT_FULL:  if (out_ready && !commit) state_next = SLOT_EMPTY;
            default:    state_next = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_kind <= 2'b00;
            out_dir  <= 3'd0;
        end else if (commit) begin
            out_kind <= cur.kind;
            out_dir  <= cur.dir;
        end
    end

endmodule

// File: tb/tb_arrow_vote_filter.sv
// tb/tb_arrow_vote_filter.sv - directed vector bench for arrow_vote_filter
module tb_arrow_vote_filter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] neuron_in = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [1:0] out_kind;
    logic [2:0] out_dir;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       v;
        logic [7:0] vec;
        logic       r;
        logic       ev;
        logic [1:0] ek;
        logic [2:0] ed;
    } vec_t;

    vec_t tv[$];

    arrow_vote_filter #(.STABLE_FRAMES(3), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .neuron_in (neuron_in),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_dir   (out_dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic ev, input logic [1:0] ek, input logic [2:0] ed);
        check({name, ".valid"}, {7'd0, out_valid}, {7'd0, ev});
        if (ev) begin
            check({name, ".kind"}, {6'd0, out_kind}, {6'd0, ek});
            check({name, ".dir"},  {5'd0, out_dir},  {5'd0, ed});
        end
    endtask

    task automatic add(input logic v, input logic [7:0] vec, input logic r,
                       input logic ev, input logic [1:0] ek, input logic [2:0] ed);
        vec_t t;
        t.v = v; t.vec = vec; t.r = r; t.ev = ev; t.ek = ek; t.ed = ed;
        tv.push_back(t);
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge
    task automatic step(input logic v, input logic [7:0] vec, input logic r);
        in_valid  = v;
        neuron_in = vec;
        out_ready = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // steady 8'h01 commits once
        add(1, 8'h01, 1, 0, 0, 0);
        add(1, 8'h01, 1, 0, 0, 0);
        add(1, 8'h01, 1, 1, 2'b00, 0);
        add(0, 8'h00, 1, 0, 0, 0);
        add(1, 8'h01, 1, 0, 0, 0);
        add(1, 8'h01, 1, 0, 0, 0);
        // interrupted run of 8'h80
        add(1, 8'h80, 1, 0, 0, 0);
        add(1, 8'h80, 1, 0, 0, 0);
        add(1, 8'h00, 1, 0, 0, 0);
        add(1, 8'h80, 1, 0, 0, 0);
        add(1, 8'h80, 1, 0, 0, 0);
        add(1, 8'h80, 1, 1, 2'b00, 7);
        add(0, 8'h00, 1, 0, 0, 0);
        // ambiguous then none
        add(1, 8'h03, 1, 0, 0, 0);
        add(1, 8'h03, 1, 0, 0, 0);
        add(1, 8'h03, 1, 1, 2'b10, 0);
        add(0, 8'h00, 1, 0, 0, 0);
        add(1, 8'h00, 1, 0, 0, 0);
        add(1, 8'h00, 1, 0, 0, 0);
        add(1, 8'h00, 1, 1, 2'b01, 0);
        add(0, 8'h00, 1, 0, 0, 0);
        // back-pressure holds output, blocked commit retried
        add(1, 8'h08, 0, 0, 0, 0);
        add(1, 8'h08, 0, 0, 0, 0);
        add(1, 8'h08, 0, 1, 2'b00, 3);
        for (int i = 0; i < 5; i++) add(1, 8'h10, 0, 1, 2'b00, 3);
        add(0, 8'h00, 1, 0, 0, 0);
        add(1, 8'h10, 1, 1, 2'b00, 4);
        add(0, 8'h00, 1, 0, 0, 0);
        // accept and commit in the same cycle replaces the slot contents
        add(1, 8'h20, 0, 0, 0, 0);
        add(1, 8'h20, 0, 0, 0, 0);
        add(1, 8'h20, 0, 1, 2'b00, 5);
        add(1, 8'h40, 0, 1, 2'b00, 5);
        add(1, 8'h40, 0, 1, 2'b00, 5);
        add(1, 8'h40, 0, 1, 2'b00, 5);
        add(1, 8'h40, 1, 1, 2'b00, 6);
        add(0, 8'h00, 1, 0, 0, 0);
        // repeat of the committed verdict after a short other run
        add(1, 8'h01, 1, 0, 0, 0);
        add(1, 8'h40, 1, 0, 0, 0);
        add(1, 8'h40, 1, 0, 0, 0);
        add(1, 8'h40, 1, 0, 0, 0);

        // reset held with random inputs
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom));
            check_out("reset_hold", 0, 0, 0);
            check("reset_hold.kind", {6'd0, out_kind}, 8'h00);
            check("reset_hold.dir",  {5'd0, out_dir},  8'h00);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1);
            check("reset_idle.valid", {7'd0, out_valid}, 8'h00);
            check("reset_idle.kind",  {6'd0, out_kind},  8'h00);
            check("reset_idle.dir",   {5'd0, out_dir},   8'h00);
        end

        foreach (tv[i]) begin
            step(tv[i].v, tv[i].vec, tv[i].r);
            check_out($sformatf("vec%0d", i), tv[i].ev, tv[i].ek, tv[i].ed);
        end

        // pending output and partial run discarded by async reset
        step(1, 8'h01, 0);
        step(1, 8'h01, 0);
        step(1, 8'h01, 0);
        check_out("pre_reset", 1, 2'b00, 0);
        step(1, 8'h04, 0);
        step(1, 8'h04, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset.valid", {7'd0, out_valid}, 8'h00);
        check("async_reset.kind",  {6'd0, out_kind},  8'h00);
        check("async_reset.dir",   {5'd0, out_dir},   8'h00);
        #1 rst_n = 1'b1;
        @(negedge clk);
        step(1, 8'h04, 1);
        check_out("post_reset_f1", 0, 0, 0);
        step(1, 8'h04, 1);
        check_out("post_reset_f2", 0, 0, 0);
        step(1, 8'h04, 1);
        check_out("post_reset_f3", 1, 2'b00, 2);
        step(0, 8'h00, 1);
        check_out("post_reset_drain", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
